// File: rtl/wide_addsub_seq.sv
// Multi-cycle wide adder/subtractor: one W-bit slice per cycle, ripple carry
// held in a register, NZCV flags produced after the last slice settles.

module wide_addsub_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] beff;

    assign beff        = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, beff} + (W+1)'(cin);
endmodule

module wide_addsub_seq #(
    parameter int W     = 32,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [W*WORDS-1:0] A,
    input  logic [W*WORDS-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W*WORDS-1:0] R,
    output logic             N_flag,
    output logic             Z_flag,
    output logic             C_flag,
    output logic             V_flag,
    output logic             busy
);
    localparam int L  = W * WORDS;
    localparam int IW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [L-1:0]    a_q, b_q, r_q;
    logic            op_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic            n_q, z_q, c_q, v_q;

    logic [W-1:0]    a_sl, b_sl, sum_sl;
    logic            cout_sl;
    logic            slices_done;

    // idx_q == WORDS is one extra RUN cycle that folds flags from the settled R,
    // which gives the WORDS+1 edge accept-to-valid latency.
    assign slices_done = (idx_q == IW'(WORDS));

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IW'(k)) begin
                a_sl = a_q[k*W +: W];
                b_sl = b_q[k*W +: W];
            end
        end
    end

    wide_addsub_slice #(.W(W)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .sub  (op_q),
        .cin  (carry_q),
        .sum  (sum_sl),
        .cout (cout_sl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)    state_d = RUN;
            RUN:     if (slices_done) state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= op_sub;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (!slices_done) begin
                        for (int k = 0; k < WORDS; k++)
                            if (idx_q == IW'(k)) r_q[k*W +: W] <= sum_sl;
                        carry_q <= cout_sl;
                        idx_q   <= idx_q + IW'(1);
                    end else begin
                        // carry_q now holds the carry out of the top slice
                        n_q <= r_q[L-1];
                        z_q <= (r_q == '0);
                        c_q <= op_q ? ~carry_q : carry_q;
                        v_q <= (a_q[L-1] == (op_q ^ b_q[L-1])) && (r_q[L-1] != a_q[L-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign R         = r_q;
    assign N_flag    = n_q;
    assign Z_flag    = z_q;
    assign C_flag    = c_q;
    assign V_flag    = v_q;
endmodule

// File: tb/tb_wide_addsub_seq.sv
// Directed bench for wide_addsub_seq at W=32, WORDS=4: latency, NZCV flags,
// backpressure, ignored mid-operation inputs and mid-RUN reset.

module tb_wide_addsub_seq;
    localparam int W     = 32;
    localparam int WORDS = 4;
    localparam int L     = W * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, op_sub;
    logic [L-1:0] A, B, R;
    logic         out_valid, out_ready;
    logic         N_flag, Z_flag, C_flag, V_flag, busy;

    int tests = 0;
    int fails = 0;

    wide_addsub_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .N_flag    (N_flag),
        .Z_flag    (Z_flag),
        .C_flag    (C_flag),
        .V_flag    (V_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L-1:0] flags();
        return L'({N_flag, Z_flag, C_flag, V_flag});
    endfunction

    // flags argument is {N,Z,C,V}
    task automatic do_op(input string tag, input logic [L-1:0] a, input logic [L-1:0] b,
                         input logic sub, input logic [L-1:0] er, input logic [3:0] ef,
                         input int hold);
        logic early;
        in_valid = 1'b1; A = a; B = b; op_sub = sub;
        @(posedge clk); #1;
        check({tag, ".accept_busy"}, L'(busy), L'(1));
        check({tag, ".accept_rdy"},  L'(in_ready), L'(0));
        // scrambled inputs and a stray out_ready during RUN must be ignored
        A = ~a; B = ~b; op_sub = ~sub; out_ready = 1'b1;
        early = 1'b0;
        repeat (WORDS) begin
            @(posedge clk); #1;
            if (out_valid) early = 1'b1;
        end
        check({tag, ".early_valid"}, L'(early), L'(0));
        out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".valid_edge5"}, L'(out_valid), L'(1));
        check({tag, ".R"},     R, er);
        check({tag, ".NZCV"},  flags(), L'(ef));
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, ".hold_R"},    R, er);
            check({tag, ".hold_NZCV"}, flags(), L'(ef));
            check({tag, ".hold_ctl"},  L'({out_valid, in_ready, busy}), L'(3'b101));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".idle_ctl"}, L'({out_valid, in_ready, busy}), L'(3'b010));
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
        A = '0; B = '0;
        #12;
        check("reset_ctl",  L'({out_valid, in_ready, busy}), L'(3'b010));
        check("reset_R",    R, '0);
        check("reset_NZCV", flags(), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_wrap", {L{1'b1}}, L'(1), 1'b0, '0, 4'b0110, 0);
        do_op("sub_neg",  L'(5), L'(7), 1'b1, {{(L-1){1'b1}}, 1'b0}, 4'b1010, 0);
        do_op("add_ovf",  {1'b0, {(L-1){1'b1}}}, L'(1), 1'b0, {1'b1, {(L-1){1'b0}}}, 4'b1001, 0);
        do_op("sub_eq",   128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                          128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1, '0, 4'b0100, 0);
        do_op("add_xslice", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, L'(1), 1'b0,
                          128'h0000_0000_0000_0000_0000_0001_0000_0000, 4'b0000, 3);

        // reset two cycles into RUN
        in_valid = 1'b1; A = 128'h1234; B = 128'h5678; op_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_rst_ctl",  L'({out_valid, in_ready, busy}), L'(3'b010));
        check("midrun_rst_R",    R, '0);
        check("midrun_rst_NZCV", flags(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", L'(1), L'(2), 1'b0, L'(3), 4'b0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
